motor_cmd_scheduler: RTL and testbench

Frame-synchronous sequencer that owns the four 12-bit motor commands (0..1000, offset added downstream) feeding the PWM encoder.
- Accepts throttle commands from the flight-control loop over a valid/ready handshake.
- Runs the ESC arming state machine.
- Applies per-frame slew limiting.
- Forces zero throttle on disarm or command timeout (failsafe).
- Output updates are aligned to the PWM frame period, so no pulse sees a mid-frame change (except safety zeroing).

---
 rtl/motor_cmd_scheduler.sv | 167 ++++++++++++++++
 tb/tb_motor_cmd_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_scheduler.sv
// Frame-synchronous throttle sequencer for four ESCs: arming, per-frame slew
// limiting, and zeroing on disarm or command timeout.
module motor_cmd_scheduler #(
  parameter int FRAME_CYC      = 20002,
  parameter int MAX_VAL        = 1000,
  parameter int SLEW_STEP      = 50,
  parameter int ARM_FRAMES     = 50,
  parameter int TIMEOUT_FRAMES = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm_req,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_val [0:3],
  output logic [11:0] val [0:3],
  output logic        frame_strobe,
  output logic        armed,
  output logic        failsafe
);

  // state    | meaning
  // DISARMED | val held at zero, waiting for arm_req at a frame boundary
  // ARMING   | arm_req held, counting frames before commands are honoured
  // ARMED    | latched commands drive val through the slew limiter
  // FAILSAFE | command timeout, val zero until arm_req drops
  typedef enum logic [1:0] {DISARMED, ARMING, ARMED, FAILSAFE} state_t;

  localparam int CNT_W = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam int ARM_W = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;
  localparam int TO_W  = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAME_CYC - 1);
  localparam logic [ARM_W-1:0]   ARM_LAST = ARM_W'(ARM_FRAMES - 1);
  localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(TIMEOUT_FRAMES - 1);
  localparam logic [11:0]        MAX_V    = 12'(MAX_VAL);
  localparam logic [11:0]        STEP_V   = 12'(SLEW_STEP);
  localparam logic signed [12:0] STEP_S   = 13'(SLEW_STEP);

  logic [CNT_W-1:0] cnt;
  logic             pend_full;
  logic [11:0]      pend [0:3];
  logic             accept;

  state_t           state, state_nxt;
  logic [ARM_W-1:0] arm_cnt, arm_cnt_nxt;
  logic [TO_W-1:0]  since_cmd, since_nxt;
  logic [11:0]      target [0:3];
  logic [11:0]      target_nxt [0:3];
  logic [11:0]      val_nxt [0:3];

  function automatic logic [11:0] clamp(input logic [11:0] x);
    clamp = (x > MAX_V) ? MAX_V : x;
  endfunction

  // Operands stay within 0..MAX_VAL, so a 13-bit signed difference cannot wrap.
  function automatic logic [11:0] slew(input logic [11:0] cur, input logic [11:0] tgt);
    logic signed [12:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP_S)       slew = cur + STEP_V;
    else if (diff < -STEP_S) slew = cur - STEP_V;
    else                     slew = tgt;
  endfunction

  always_comb begin
    frame_strobe = (cnt == CNT_LAST);
    cmd_ready    = !pend_full || frame_strobe;
    accept       = cmd_valid && cmd_ready;
    armed        = (state == ARMED);
    failsafe     = (state == FAILSAFE);
  end

  always_ff @(posedge clk) begin
    if (rst || frame_strobe) cnt <= '0;
    else                     cnt <= cnt + CNT_W'(1);
  end

  // A strobe consumes the held entry; an accept in the same cycle refills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full <= 1'b0;
      for (int i = 0; i < 4; i++) pend[i] <= '0;
    end else if (accept) begin
      pend_full <= 1'b1;
      for (int i = 0; i < 4; i++) pend[i] <= clamp(cmd_val[i]);
    end else if (frame_strobe) begin
      pend_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DISARMED;
      arm_cnt   <= '0;
      since_cmd <= '0;
      for (int i = 0; i < 4; i++) begin
        target[i] <= '0;
        val[i]    <= '0;
      end
    end else begin
      state     <= state_nxt;
      arm_cnt   <= arm_cnt_nxt;
      since_cmd <= since_nxt;
      for (int i = 0; i < 4; i++) begin
        target[i] <= target_nxt[i];
        val[i]    <= val_nxt[i];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    arm_cnt_nxt = arm_cnt;
    since_nxt   = since_cmd;
    for (int i = 0; i < 4; i++) begin
      target_nxt[i] = target[i];
      val_nxt[i]    = val[i];
    end

    // Disarm is honoured immediately, not at the frame boundary.
    if (state != DISARMED && !arm_req) begin
      state_nxt = DISARMED;
      for (int i = 0; i < 4; i++) begin
        target_nxt[i] = '0;
        val_nxt[i]    = '0;
      end
    end else if (frame_strobe) begin
      case (state)
        DISARMED: begin
          if (arm_req) begin
            state_nxt   = ARMING;
            arm_cnt_nxt = '0;
          end
        end
        ARMING: begin
          if (arm_cnt == ARM_LAST) begin
            state_nxt = ARMED;
            since_nxt = '0;
            for (int i = 0; i < 4; i++) target_nxt[i] = pend_full ? pend[i] : 12'd0;
          end else begin
            arm_cnt_nxt = arm_cnt + ARM_W'(1);
          end
        end
        ARMED: begin
          if (pend_full) begin
            since_nxt = '0;
            for (int i = 0; i < 4; i++) begin
              target_nxt[i] = pend[i];
              val_nxt[i]    = slew(val[i], pend[i]);
            end
          end else if (since_cmd == TO_LAST) begin
            state_nxt = FAILSAFE;
            for (int i = 0; i < 4; i++) val_nxt[i] = '0;
          end else begin
            since_nxt = since_cmd + TO_W'(1);
            for (int i = 0; i < 4; i++) val_nxt[i] = slew(val[i], target[i]);
          end
        end
        FAILSAFE: begin
          for (int i = 0; i < 4; i++) val_nxt[i] = '0;
        end
        default: state_nxt = DISARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Bench for motor_cmd_scheduler: directed scenarios plus random traffic, all
// outputs compared every cycle against a frame-level behavioural model.
module tb_motor_cmd_scheduler;

  localparam int FRAME_CYC      = 100;
  localparam int MAX_VAL        = 1000;
  localparam int SLEW_STEP      = 50;
  localparam int ARM_FRAMES     = 3;
  localparam int TIMEOUT_FRAMES = 4;

  logic        clk = 1'b0;
  logic        rst, arm_req, cmd_valid;
  logic [11:0] cmd_val [0:3];
  logic        cmd_ready;
  logic [11:0] val [0:3];
  logic        frame_strobe, armed, failsafe;

  always #5 clk = ~clk;

  motor_cmd_scheduler #(
    .FRAME_CYC(FRAME_CYC), .MAX_VAL(MAX_VAL), .SLEW_STEP(SLEW_STEP),
    .ARM_FRAMES(ARM_FRAMES), .TIMEOUT_FRAMES(TIMEOUT_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .arm_req(arm_req), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_val(cmd_val), .val(val),
    .frame_strobe(frame_strobe), .armed(armed), .failsafe(failsafe)
  );

  int n_err = 0;
  int n_chk = 0;

  localparam int M_OFF = 0, M_ARMING = 1, M_ON = 2, M_FS = 3;
  int m_cnt, m_mode, m_arm_frames, m_quiet, m_pend_ok;
  int m_pend [4];
  int m_target [4];
  int m_val [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int slew_to(input int cur, input int tgt);
    if (tgt - cur > SLEW_STEP) return cur + SLEW_STEP;
    if (cur - tgt > SLEW_STEP) return cur - SLEW_STEP;
    return tgt;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_mode = M_OFF; m_arm_frames = 0; m_quiet = 0; m_pend_ok = 0;
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0; m_target[i] = 0; m_val[i] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs presented at that edge.
  task automatic model_step();
    bit strobe, acc;
    int newp [4];
    if (rst) begin
      model_reset();
      return;
    end
    strobe = (m_cnt == FRAME_CYC - 1);
    acc = cmd_valid && (!m_pend_ok || strobe);
    for (int i = 0; i < 4; i++)
      newp[i] = (int'(cmd_val[i]) > MAX_VAL) ? MAX_VAL : int'(cmd_val[i]);

    if (m_mode != M_OFF && !arm_req) begin
      m_mode = M_OFF;
      for (int i = 0; i < 4; i++) begin m_target[i] = 0; m_val[i] = 0; end
    end else if (strobe) begin
      case (m_mode)
        M_OFF: if (arm_req) begin m_mode = M_ARMING; m_arm_frames = 0; end
        M_ARMING: begin
          if (m_arm_frames == ARM_FRAMES - 1) begin
            m_mode = M_ON;
            m_quiet = 0;
            for (int i = 0; i < 4; i++) m_target[i] = m_pend_ok ? m_pend[i] : 0;
          end else begin
            m_arm_frames++;
          end
        end
        M_ON: begin
          if (m_pend_ok) begin
            m_target = m_pend;
            m_quiet = 0;
          end else begin
            m_quiet++;
          end
          if (m_quiet == TIMEOUT_FRAMES) begin
            m_mode = M_FS;
            for (int i = 0; i < 4; i++) m_val[i] = 0;
          end else begin
            for (int i = 0; i < 4; i++) m_val[i] = slew_to(m_val[i], m_target[i]);
          end
        end
        default: ;
      endcase
    end

    if (acc) begin
      m_pend_ok = 1;
      m_pend = newp;
    end else if (strobe) begin
      m_pend_ok = 0;
    end
    m_cnt = strobe ? 0 : m_cnt + 1;
  endtask

  task automatic check_all();
    chk("strobe", frame_strobe, (m_cnt == FRAME_CYC - 1));
    chk("ready", cmd_ready, (!m_pend_ok || m_cnt == FRAME_CYC - 1));
    chk("armed", armed, (m_mode == M_ON));
    chk("failsafe", failsafe, (m_mode == M_FS));
    for (int i = 0; i < 4; i++) chk($sformatf("val%0d", i), val[i], m_val[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Bounded on the model counter, which always wraps within one frame.
  task automatic goto_cnt(input int c);
    for (int k = 0; k < 2 * FRAME_CYC && m_cnt != c; k++) tick();
  endtask

  task automatic set_cmd(input int a, input int b, input int c, input int d);
    cmd_val[0] = 12'(a); cmd_val[1] = 12'(b); cmd_val[2] = 12'(c); cmd_val[3] = 12'(d);
  endtask

  initial begin
    int  drop_at;
    bit  quiet;
    rst = 1'b1; arm_req = 1'b0; cmd_valid = 1'b0;
    set_cmd(0, 0, 0, 0);
    model_reset();
    run(3);
    chk("rst_val0", val[0], 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_armed", armed, 0);

    // Arming: ARMED only after the fourth strobe, val stays zero.
    rst = 1'b0; arm_req = 1'b1;
    run(FRAME_CYC * 4 - 1);
    chk("arm_pre_strobe", frame_strobe, 1);
    chk("arm_pre_armed", armed, 0);
    run(1);
    chk("arm_armed", armed, 1);
    chk("arm_val0", val[0], 0);

    // Slew toward {120,0,1000,30}.
    cmd_valid = 1'b1; set_cmd(120, 0, 1000, 30);
    run(FRAME_CYC);
    chk("slew1_v0", val[0], 50);
    chk("slew1_v2", val[2], 50);
    chk("slew1_v3", val[3], 30);
    run(FRAME_CYC);
    chk("slew2_v0", val[0], 100);
    run(FRAME_CYC);
    chk("slew3_v0", val[0], 120);
    run(FRAME_CYC * 17);
    chk("slew20_v2", val[2], 1000);
    chk("slew20_v1", val[1], 0);

    // Clamp and handshake back-pressure.
    cmd_valid = 1'b0;
    run(FRAME_CYC);
    cmd_valid = 1'b1; set_cmd(500, 4000, 500, 500);
    tick();
    set_cmd(10, 10, 10, 10);
    tick();
    chk("hs_busy_ready", cmd_ready, 0);
    goto_cnt(0);
    cmd_valid = 1'b0;
    chk("clamp_v0", val[0], 170);
    chk("clamp_v1", val[1], 50);
    chk("clamp_v2", val[2], 950);
    run(FRAME_CYC);
    chk("onstrobe_v0", val[0], 120);
    chk("onstrobe_v1", val[1], 10);

    // Timeout into FAILSAFE, then disarm.
    run(FRAME_CYC * 4 - 1);
    chk("to_pre_fs", failsafe, 0);
    run(1);
    chk("to_fs", failsafe, 1);
    chk("to_val0", val[0], 0);
    cmd_valid = 1'b1; set_cmd(700, 700, 700, 700);
    run(FRAME_CYC * 2);
    chk("fs_hold", failsafe, 1);
    chk("fs_hold_val", val[0], 0);
    arm_req = 1'b0;
    tick();
    chk("fs_disarm", failsafe, 0);

    // Re-arm, ramp to 600, then immediate disarm mid-frame.
    arm_req = 1'b1; set_cmd(600, 600, 600, 600);
    run(FRAME_CYC * 18);
    chk("ramp_v0", val[0], 600);
    goto_cnt(37);
    arm_req = 1'b0;
    tick();
    chk("disarm_val0", val[0], 0);
    chk("disarm_armed", armed, 0);
    arm_req = 1'b1;
    run(61 + FRAME_CYC * 3);
    chk("rearm_pre", armed, 0);
    run(1);
    chk("rearm", armed, 1);

    // Mid-frame reset while ARMED.
    set_cmd(500, 500, 500, 500);
    run(FRAME_CYC * 11);
    chk("pre_rst_v0", val[0], 500);
    goto_cnt(55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_val0", val[0], 0);
    chk("mrst_armed", armed, 0);
    chk("mrst_ready", cmd_ready, 1);
    run(FRAME_CYC - 2);
    chk("mrst_cnt_pre", frame_strobe, 0);
    run(1);
    chk("mrst_cnt", frame_strobe, 1);

    // Random traffic.
    drop_at = -1;
    quiet = 1'b0;
    arm_req = 1'b1;
    for (int k = 0; k < 60 * FRAME_CYC; k++) begin
      if (m_cnt == 0) begin
        drop_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, FRAME_CYC - 1)) : -1;
        if ($urandom_range(0, 5) == 0) quiet = !quiet;
      end
      arm_req = (m_cnt != drop_at);
      rst = ($urandom_range(0, 2999) == 0);
      cmd_valid = !quiet && ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 4; i++) cmd_val[i] = 12'($urandom_range(0, 1300));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
